pipe_stage_reg: RTL and testbench

- Parametrised pipeline stage register; the next generation of the inter-stage latches (IF/ID … MEM/WB).
- Carries an opaque data payload plus a control bundle (register, HI/LO and CP0 write enables) between two stages using a valid/ready handshake.
- Optional 2-entry skid buffer breaks the combinational ready path.
- Flush squashes in-flight instructions without losing ordering, and bubble control bits are always forced to zero.
- Two saturating performance counters are exposed for the debug bus.

---
 rtl/pipe_stage_reg.sv | 138 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// flush squash and saturating stall/bubble counters for the debug bus.
//
// Ports:
//   clk, rst (async active-low), flush (sync squash)
//   in_valid/in_ready/in_data/in_ctrl     : upstream beat
//   out_valid/out_ready/out_data/out_ctrl : downstream beat (ctrl gated)
//   stall_cnt  : cycles with out_valid=1 and out_ready=0 (saturating)
//   bubble_cnt : cycles with out_valid=0 (saturating)
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic              main_v_q, main_v_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;

  logic up_xfer;
  logic dn_xfer;

  generate
    if (SKID != 0) begin : g_skid
      // Straight from a flop: no path from out_ready to in_ready.
      assign in_ready = ~skid_v_q;
    end else begin : g_noskid
      assign in_ready = ~main_v_q | out_ready;
    end
  endgenerate

  assign dn_xfer = main_v_q & out_ready;
  // A beat offered during flush is dropped even if in_ready is high.
  assign up_xfer = in_valid & in_ready & ~flush;

  always_comb begin
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (SKID != 0) begin
      // skid_v=1 forces in_ready=0, so refill
      // from skid never races an upstream beat.
      if (dn_xfer && skid_v_q) begin
        main_data_d = skid_data_q;
        main_ctrl_d = skid_ctrl_q;
        main_v_d    = 1'b1;
        skid_v_d    = 1'b0;
      end else if (up_xfer && (!main_v_q || dn_xfer)) begin
        main_data_d = in_data;
        main_ctrl_d = in_ctrl;
        main_v_d    = 1'b1;
      end else if (up_xfer) begin
        skid_data_d = in_data;
        skid_ctrl_d = in_ctrl;
        skid_v_d    = 1'b1;
      end else if (dn_xfer) begin
        main_v_d = 1'b0;
      end
    end else begin
      if (up_xfer) begin
        main_data_d = in_data;
        main_ctrl_d = in_ctrl;
        main_v_d    = 1'b1;
      end else if (dn_xfer) begin
        main_v_d = 1'b0;
      end
    end
  end

  // Counters look at pre-flush main_v and ignore flush.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (main_v_q && !out_ready && stall_q != CNT_MAX)
      stall_d = stall_q + CNT_ONE;
    if (!main_v_q && bubble_q != CNT_MAX)
      bubble_d = bubble_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      stall_q     <= '0;
      bubble_q    <= '0;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_q     <= stall_d;
      bubble_q    <= bubble_d;
    end
  end

  assign out_valid  = main_v_q;
  assign out_data   = main_data_q;
  // Write enables must never assert on a bubble.
  assign out_ctrl   = main_ctrl_q & {CTRL_W{main_v_q}};
  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1/CNT_W=16 and SKID=0/CNT_W=4 instances,
// directed beats with a queue scoreboard checked by per-instance monitors.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_flush = 0, a_in_valid = 0, a_out_ready = 0;
  logic        a_in_ready, a_out_valid;
  logic [31:0] a_in_data = 0, a_out_data;
  logic [7:0]  a_in_ctrl = 0, a_out_ctrl;
  logic [15:0] a_stall, a_bubble;

  logic        b_flush = 0, b_in_valid = 0, b_out_ready = 0;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_in_data = 0, b_out_data;
  logic [7:0]  b_in_ctrl = 0, b_out_ctrl;
  logic [3:0]  b_stall, b_bubble;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_ctrl(a_in_ctrl),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_ctrl(a_out_ctrl),
    .stall_cnt(a_stall), .bubble_cnt(a_bubble));

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_ctrl(b_in_ctrl),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_ctrl(b_out_ctrl),
    .stall_cnt(b_stall), .bubble_cnt(b_bubble));

  int nvec = 0;
  int nbad = 0;
  logic [39:0] qa[$];
  logic [39:0] qb[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        nvec++; nbad++;
        $display("FAIL a_unexpected: got 0x%0h want none", a_out_data);
      end else begin
        logic [39:0] e;
        e = qa.pop_front();
        check("a_out_data", a_out_data, e[31:0]);
        check("a_out_ctrl", {24'd0, a_out_ctrl}, {24'd0, e[39:32]});
      end
    end
  end

  always @(negedge clk) begin
    if (rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        nvec++; nbad++;
        $display("FAIL b_unexpected: got 0x%0h want none", b_out_data);
      end else begin
        logic [39:0] e;
        e = qb.pop_front();
        check("b_out_data", b_out_data, e[31:0]);
        check("b_out_ctrl", {24'd0, b_out_ctrl}, {24'd0, e[39:32]});
      end
    end
  end

  // One clock of stimulus on instance A; returns whether the beat is taken.
  task automatic cyc_a(input logic v, input logic [31:0] d,
                       input logic [7:0] c, input logic ordy,
                       input logic fl, output logic acc);
    a_in_valid = v; a_in_data = d; a_in_ctrl = c;
    a_out_ready = ordy; a_flush = fl;
    @(negedge clk); #1;
    acc = v & a_in_ready & ~fl;
    if (acc) qa.push_back({c, d});
    @(posedge clk);
    if (fl) qa.delete();
    #1;
    a_in_valid = 0; a_flush = 0;
  endtask

  task automatic cyc_b(input logic v, input logic [31:0] d,
                       input logic [7:0] c, input logic ordy,
                       output logic acc);
    b_in_valid = v; b_in_data = d; b_in_ctrl = c;
    b_out_ready = ordy;
    @(negedge clk); #1;
    acc = v & b_in_ready;
    if (acc) qb.push_back({c, d});
    @(posedge clk); #1;
    b_in_valid = 0;
  endtask

  initial begin
    logic acc;
    #1 rst = 0;
    #2;
    check("rst_a_out_valid", {31'd0, a_out_valid}, 0);
    check("rst_a_out_data", a_out_data, 0);
    check("rst_a_out_ctrl", {24'd0, a_out_ctrl}, 0);
    check("rst_a_in_ready", {31'd0, a_in_ready}, 1);
    check("rst_b_in_ready", {31'd0, b_in_ready}, 1);
    check("rst_b_out_ctrl", {24'd0, b_out_ctrl}, 0);
    @(posedge clk); #1 rst = 1;
    b_out_ready = 1;

    // B idles: bubble counter climbs then saturates at 15.
    repeat (10) @(posedge clk);
    #1 check("b_bubble_10", {28'd0, b_bubble}, 10);
    repeat (10) @(posedge clk);
    #1 check("b_bubble_sat", {28'd0, b_bubble}, 15);
    repeat (5) @(posedge clk);
    #1 check("b_bubble_hold", {28'd0, b_bubble}, 15);
    @(posedge clk); #1;

    // Streaming through A.
    for (int i = 0; i < 5; i++) begin
      cyc_a(1, 32'h100 + i, 8'(i + 1), 1, 0, acc);
      check("stream_in_ready", {31'd0, acc}, 1);
    end
    repeat (3) cyc_a(0, 0, 0, 1, 0, acc);
    check("stream_stall", {16'd0, a_stall}, 0);

    // Backpressure: A in main, B in skid, C refused until drain.
    cyc_a(1, 32'hA, 8'h11, 0, 0, acc);
    check("bp_acc_a", {31'd0, acc}, 1);
    cyc_a(1, 32'hB, 8'h22, 0, 0, acc);
    check("bp_acc_b", {31'd0, acc}, 1);
    check("bp_in_ready_full", {31'd0, a_in_ready}, 0);
    for (int i = 0; i < 3; i++) begin
      cyc_a(1, 32'hC, 8'h33, 0, 0, acc);
      check("bp_c_refused", {31'd0, acc}, 0);
    end
    check("bp_hold_data", a_out_data, 32'hA);
    cyc_a(1, 32'hC, 8'h33, 1, 0, acc);
    check("bp_c_still_refused", {31'd0, acc}, 0);
    cyc_a(1, 32'hC, 8'h33, 1, 0, acc);
    check("bp_acc_c", {31'd0, acc}, 1);
    repeat (3) cyc_a(0, 0, 0, 1, 0, acc);
    check("bp_stall", {16'd0, a_stall}, 4);

    // Flush with two held entries and a colliding beat.
    cyc_a(1, 32'h1, 8'hFF, 0, 0, acc);
    cyc_a(1, 32'h2, 8'hFF, 0, 0, acc);
    check("fl_pre_ctrl", {24'd0, a_out_ctrl}, 32'hFF);
    check("fl_pre_in_ready", {31'd0, a_in_ready}, 0);
    cyc_a(1, 32'hD, 8'h0F, 0, 1, acc);
    check("fl_out_valid", {31'd0, a_out_valid}, 0);
    check("fl_out_ctrl", {24'd0, a_out_ctrl}, 0);
    check("fl_in_ready", {31'd0, a_in_ready}, 1);
    repeat (3) cyc_a(0, 0, 0, 1, 0, acc);

    // SKID=0 pass-through ready.
    cyc_b(1, 32'h21, 8'h01, 0, acc);
    check("b_acc_21", {31'd0, acc}, 1);
    cyc_b(1, 32'h99, 8'h09, 0, acc);
    check("b_refuse_full", {31'd0, acc}, 0);
    cyc_b(1, 32'h22, 8'h02, 1, acc);
    check("b_comb_ready", {31'd0, acc}, 1);
    check("b_no_bubble", {31'd0, b_out_valid}, 1);
    check("b_replaced", b_out_data, 32'h22);
    cyc_b(1, 32'h23, 8'h03, 1, acc);
    check("b_acc_23", {31'd0, acc}, 1);
    repeat (2) cyc_b(0, 0, 0, 1, acc);
    check("b_stall", {28'd0, b_stall}, 1);

    // Async reset between edges with two entries held.
    cyc_a(1, 32'h3, 8'hC3, 0, 0, acc);
    cyc_a(1, 32'h4, 8'hC4, 0, 0, acc);
    #3 rst = 0;
    #1;
    check("ar_out_valid", {31'd0, a_out_valid}, 0);
    check("ar_out_ctrl", {24'd0, a_out_ctrl}, 0);
    check("ar_stall", {16'd0, a_stall}, 0);
    check("ar_bubble", {16'd0, a_bubble}, 0);
    check("ar_b_bubble", {28'd0, b_bubble}, 0);
    check("ar_in_ready", {31'd0, a_in_ready}, 1);
    qa.delete();
    qb.delete();
    @(posedge clk); #1 rst = 1;
    cyc_a(1, 32'h55, 8'h5A, 1, 0, acc);
    check("ar_acc_55", {31'd0, acc}, 1);
    check("ar_55_valid", {31'd0, a_out_valid}, 1);
    check("ar_55_data", a_out_data, 32'h55);
    repeat (2) cyc_a(0, 0, 0, 1, 0, acc);

    check("a_queue_empty", qa.size(), 0);
    check("b_queue_empty", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
